// File: rtl/hbm_model_reader.sv
// Streams a contiguous HBM region out as 512-bit words built from pairs of 256-bit AXI3 beats.
// Latency: first AR 2 cycles after start, words 1 cycle after the odd beat; AR issue stalls on almost_full, R is always accepted.
module hbm_model_reader #(
  parameter int ADDR_W          = 34,
  parameter int BURST_BEATS     = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              hbm_clk,
  input  logic              hbm_aresetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_base,
  input  logic [31:0]       data_length,
  input  logic              almost_full,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [3:0]        m_axi_arlen,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [255:0]      m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [511:0]      back_data,
  output logic              back_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  next_addr_q, next_addr_d;
  logic [26:0]        beats_to_issue_q, beats_to_issue_d;
  logic [26:0]        beats_to_recv_q, beats_to_recv_d;
  logic [OUT_W-1:0]   outstanding_q, outstanding_d;
  logic               arvalid_q, arvalid_d;
  logic [ADDR_W-1:0]  araddr_q, araddr_d;
  logic [3:0]         arlen_q, arlen_d;
  logic               rready_q, rready_d;
  logic               half_q, half_d;
  logic [255:0]       low_q, low_d;
  logic [511:0]       back_data_q, back_data_d;
  logic               back_valid_q, back_valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               ar_hs;
  logic               r_hs;
  logic [26:0]        burst_beats;
  logic [9:0]         burst_bytes;
  logic [26:0]        issue_left;

  always_comb begin
    ar_hs       = arvalid_q & m_axi_arready;
    r_hs        = m_axi_rvalid & rready_q;
    burst_beats = (beats_to_issue_q > 27'(BURST_BEATS)) ? 27'(BURST_BEATS) : beats_to_issue_q;
    // arlen_q still describes the burst being handshaken, so it drives the bookkeeping
    burst_bytes = ({6'd0, arlen_q} + 10'd1) << 5;
    issue_left  = beats_to_issue_q - {23'd0, arlen_q} - 27'd1;

    state_d          = state_q;
    next_addr_d      = next_addr_q;
    beats_to_issue_d = beats_to_issue_q;
    beats_to_recv_d  = beats_to_recv_q;
    outstanding_d    = outstanding_q;
    arvalid_d        = arvalid_q;
    araddr_d         = araddr_q;
    arlen_d          = arlen_q;
    rready_d         = 1'b1;
    half_d           = half_q;
    low_d            = low_q;
    back_data_d      = back_data_q;
    back_valid_d     = 1'b0;
    done_d           = (state_q == S_DONE);
    err_d            = err_q;

    if (r_hs) begin
      half_d = ~half_q;
      if (!half_q) begin
        low_d = m_axi_rdata;
      end else begin
        back_data_d  = {m_axi_rdata, low_q};
        back_valid_d = 1'b1;
      end
      if (beats_to_recv_q != 27'd0) begin
        beats_to_recv_d = beats_to_recv_q - 27'd1;
      end
      if (m_axi_rresp != 2'b00) begin
        err_d = 1'b1;
      end
    end

    case ({ar_hs, r_hs & m_axi_rlast})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          next_addr_d      = addr_base;
          beats_to_issue_d = data_length[31:5];
          beats_to_recv_d  = data_length[31:5];
          err_d            = 1'b0;
          state_d          = (data_length == 32'd0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!arvalid_q && (outstanding_q < OUT_W'(MAX_OUTSTANDING)) && !almost_full
            && (beats_to_issue_q != 27'd0)) begin
          arvalid_d = 1'b1;
          araddr_d  = next_addr_q;
          arlen_d   = 4'(burst_beats - 27'd1);
        end
        if (ar_hs) begin
          arvalid_d        = 1'b0;
          next_addr_d      = next_addr_q + ADDR_W'(burst_bytes);
          beats_to_issue_d = issue_left;
          if (issue_left == 27'd0) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if ((beats_to_recv_q == 27'd0) && (outstanding_q == '0)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge hbm_clk or negedge hbm_aresetn) begin
    if (!hbm_aresetn) begin
      state_q          <= S_IDLE;
      next_addr_q      <= '0;
      beats_to_issue_q <= '0;
      beats_to_recv_q  <= '0;
      outstanding_q    <= '0;
      arvalid_q        <= 1'b0;
      araddr_q         <= '0;
      arlen_q          <= '0;
      rready_q         <= 1'b0;
      half_q           <= 1'b0;
      low_q            <= '0;
      back_data_q      <= '0;
      back_valid_q     <= 1'b0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      next_addr_q      <= next_addr_d;
      beats_to_issue_q <= beats_to_issue_d;
      beats_to_recv_q  <= beats_to_recv_d;
      outstanding_q    <= outstanding_d;
      arvalid_q        <= arvalid_d;
      araddr_q         <= araddr_d;
      arlen_q          <= arlen_d;
      rready_q         <= rready_d;
      half_q           <= half_d;
      low_q            <= low_d;
      back_data_q      <= back_data_d;
      back_valid_q     <= back_valid_d;
      done_q           <= done_d;
      err_q            <= err_d;
    end
  end

  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign back_data     = back_data_q;
  assign back_valid    = back_valid_q;
  // busy also covers the registered done cycle so the job never looks idle before done
  assign busy          = (state_q != S_IDLE) | done_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule
